seq_priority_encoder: RTL

Sequential 16-to-4 encoder, the inverse of the team's 4-to-16 enable-gated decoder. It accepts a 16-bit request vector and emits, one per handshake, the 4-bit index of every set bit, lowest index first. Each emitted bit is cleared from its internal pending register. It sits between request-collection logic and any consumer that needs binary indices (e.g. a decoder-driven select bus). It tracks how many requests are pending and flags empty loads.

---
 rtl/seq_priority_encoder.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/seq_priority_encoder.sv
// Sequential 16-to-4 priority encoder: it captures a request vector and then
// emits the index of each set bit, lowest first, one per valid/ready handshake.
module seq_priority_encoder #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic [IDX_W:0]   pend_cnt,
  output logic             empty_err,
  output logic             done
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  localparam logic [IDX_W:0] CNT_ONE = {{IDX_W{1'b0}}, 1'b1};

  state_t           state_r;
  logic [WIDTH-1:0] pend_r;
  logic [IDX_W:0]   cnt_r;
  logic             empty_err_r;
  logic             done_r;
  logic             load_ready_s;
  logic             out_valid_s;
  logic [IDX_W-1:0] out_idx_s;
  logic             out_last_s;

  function automatic logic [IDX_W:0] popcount(input logic [WIDTH-1:0] v);
    logic [IDX_W:0] c;
    c = {(IDX_W+1){1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      c = c + {{IDX_W{1'b0}}, v[i]};
    end
    return c;
  endfunction

  // Scans from the top so the lowest set bit is the last one written.
  function automatic logic [IDX_W-1:0] lowest_idx(input logic [WIDTH-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = {IDX_W{1'b0}};
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = IDX_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Handshake qualifiers and the index presented from the pending register.
  always_comb begin
    load_ready_s = 1'b0;
    out_valid_s  = 1'b0;
    out_idx_s    = {IDX_W{1'b0}};
    out_last_s   = 1'b0;
    case (state_r)
      IDLE: begin
        load_ready_s = rst_n & en;
      end
      EMIT: begin
        out_valid_s = rst_n & en;
        if (out_valid_s) begin
          out_idx_s  = lowest_idx(pend_r);
          out_last_s = (cnt_r == CNT_ONE);
        end else begin
          out_idx_s  = {IDX_W{1'b0}};
          out_last_s = 1'b0;
        end
      end
      default: begin
        load_ready_s = 1'b0;
      end
    endcase
  end

  // State, pending bits, count and the one-cycle status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      pend_r      <= {WIDTH{1'b0}};
      cnt_r       <= {(IDX_W+1){1'b0}};
      empty_err_r <= 1'b0;
      done_r      <= 1'b0;
    end else if (en) begin
      empty_err_r <= 1'b0;
      done_r      <= 1'b0;
      case (state_r)
        IDLE: begin
          if (load_valid) begin
            pend_r <= load_vec;
            cnt_r  <= popcount(load_vec);
            if (load_vec == {WIDTH{1'b0}}) begin
              empty_err_r <= 1'b1;
            end else begin
              state_r <= EMIT;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        EMIT: begin
          if (out_ready) begin
            // v & (v - 1) drops exactly the lowest set bit, i.e. out_idx.
            pend_r <= pend_r & (pend_r - {{(WIDTH-1){1'b0}}, 1'b1});
            cnt_r  <= cnt_r - CNT_ONE;
            if (cnt_r == CNT_ONE) begin
              state_r <= IDLE;
              done_r  <= 1'b1;
            end else begin
              state_r <= EMIT;
            end
          end else begin
            state_r <= EMIT;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end else begin
      empty_err_r <= 1'b0;
      done_r      <= 1'b0;
    end
  end

  assign load_ready = load_ready_s;
  assign out_valid  = out_valid_s;
  assign out_idx    = out_idx_s;
  assign out_last   = out_last_s;
  assign pend_cnt   = cnt_r;
  assign empty_err  = empty_err_r;
  assign done       = done_r;

endmodule
